// File: rtl/frame_source.sv
// AXI4-Stream test-pattern frame transmitter: one FRAME_WIDTH x FRAME_HEIGHT frame
// per rising fsync edge, with tuser on the first beat and tlast on each line end.
module frame_source #(
  parameter int TDATA_WIDTH  = 32,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   fsync,
  input  logic                   enable,
  input  logic [1:0]             pattern_sel,
  output logic                   output_frame_tvalid,
  output logic [TDATA_WIDTH-1:0] output_frame_tdata,
  output logic                   output_frame_tuser,
  output logic                   output_frame_tlast,
  input  logic                   output_frame_tready,
  output logic                   busy,
  output logic                   frame_dropped,
  output logic [15:0]            frame_count
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [15:0] X_LAST = 16'(FRAME_WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(FRAME_HEIGHT - 1);

  state_t                 state_q, state_d;
  logic [15:0]            x_q, x_d, y_q, y_d;
  logic [TDATA_WIDTH-1:0] ramp_q, ramp_d;
  logic [1:0]             pattern_q, pattern_d;
  logic [15:0]            frame_id_q, frame_id_d;
  logic                   fsync_prev_q;
  logic                   tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                   frame_dropped_q, frame_dropped_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic                   rise_s, xfer_s, last_s, start_s;
  logic [15:0]            nx_s, ny_s;

  function automatic logic [TDATA_WIDTH-1:0] pixel(
    input logic [1:0]             pat,
    input logic [15:0]            x,
    input logic [15:0]            y,
    input logic [TDATA_WIDTH-1:0] ramp,
    input logic [15:0]            fid
  );
    logic [TDATA_WIDTH-1:0] v;
    v = {TDATA_WIDTH{1'b0}};
    case (pat)
      2'd0:    v = ramp;
      2'd1:    v[31:0] = {y, x};
      2'd2:    v = (x[3] ^ y[3]) ? {TDATA_WIDTH{1'b1}} : {TDATA_WIDTH{1'b0}};
      2'd3:    v[15:0] = fid;
      default: v = {TDATA_WIDTH{1'b0}};
    endcase
    return v;
  endfunction

  // A restart on the last beat wins over returning to IDLE, giving gapless frames.
  always_comb begin
    rise_s  = fsync & ~fsync_prev_q;
    xfer_s  = tvalid_q & output_frame_tready;
    last_s  = xfer_s && (x_q == X_LAST) && (y_q == Y_LAST);
    start_s = rise_s && enable && ((state_q == IDLE) || last_s);
    if (x_q == X_LAST) begin
      nx_s = 16'd0;
      ny_s = y_q + 16'd1;
    end else begin
      nx_s = x_q + 16'd1;
      ny_s = y_q;
    end

    state_d         = state_q;
    x_d             = x_q;
    y_d             = y_q;
    ramp_d          = ramp_q;
    pattern_d       = pattern_q;
    frame_id_d      = frame_id_q;
    tvalid_d        = tvalid_q;
    tuser_d         = tuser_q;
    tlast_d         = tlast_q;
    tdata_d         = tdata_q;
    frame_count_d   = last_s ? frame_count_q + 16'd1 : frame_count_q;
    frame_dropped_d = (state_q == ACTIVE) && rise_s && !last_s;

    if (start_s) begin
      state_d    = ACTIVE;
      pattern_d  = pattern_sel;
      frame_id_d = frame_count_d;
      x_d        = 16'd0;
      y_d        = 16'd0;
      ramp_d     = {TDATA_WIDTH{1'b0}};
      tvalid_d   = 1'b1;
      tuser_d    = 1'b1;
      tlast_d    = 1'b0;
      tdata_d    = pixel(pattern_sel, 16'd0, 16'd0, {TDATA_WIDTH{1'b0}}, frame_count_d);
    end else if (last_s) begin
      state_d  = IDLE;
      tvalid_d = 1'b0;
      tuser_d  = 1'b0;
      tlast_d  = 1'b0;
    end else if (xfer_s) begin
      x_d     = nx_s;
      y_d     = ny_s;
      ramp_d  = ramp_q + TDATA_WIDTH'(1);
      tuser_d = 1'b0;
      tlast_d = (nx_s == X_LAST);
      tdata_d = pixel(pattern_q, nx_s, ny_s, ramp_q + TDATA_WIDTH'(1), frame_id_q);
    end else begin
      state_d = state_q;
    end
  end

  // fsync history resets high so a level already high at reset release is not an edge.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q         <= IDLE;
      x_q             <= 16'd0;
      y_q             <= 16'd0;
      ramp_q          <= {TDATA_WIDTH{1'b0}};
      pattern_q       <= 2'd0;
      frame_id_q      <= 16'd0;
      fsync_prev_q    <= 1'b1;
      tvalid_q        <= 1'b0;
      tuser_q         <= 1'b0;
      tlast_q         <= 1'b0;
      tdata_q         <= {TDATA_WIDTH{1'b0}};
      frame_dropped_q <= 1'b0;
      frame_count_q   <= 16'd0;
    end else begin
      state_q         <= state_d;
      x_q             <= x_d;
      y_q             <= y_d;
      ramp_q          <= ramp_d;
      pattern_q       <= pattern_d;
      frame_id_q      <= frame_id_d;
      fsync_prev_q    <= fsync;
      tvalid_q        <= tvalid_d;
      tuser_q         <= tuser_d;
      tlast_q         <= tlast_d;
      tdata_q         <= tdata_d;
      frame_dropped_q <= frame_dropped_d;
      frame_count_q   <= frame_count_d;
    end
  end

  assign output_frame_tvalid = tvalid_q;
  assign output_frame_tdata  = tdata_q;
  assign output_frame_tuser  = tuser_q;
  assign output_frame_tlast  = tlast_q;
  assign busy                = (state_q == ACTIVE);
  assign frame_dropped       = frame_dropped_q;
  assign frame_count         = frame_count_q;

endmodule
